if_id_stage: RTL and testbench

- IF/ID pipeline register and decode front end of the 5-stage MIPS pipeline, directly downstream of instruction_fetch.
- Captures the fetched instruction and PC+4 on every active edge, then splits the held instruction into fields.
- Produces the sign-extended/shifted branch offset and the 28-bit jump target that instruction_fetch consumes.
- Detects load-use hazards and drives the `stall` input of instruction_fetch; applies flushes for taken branches and jumps.

---
 rtl/if_id_stage.sv | 105 ++++++++++
 tb/tb_if_id_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with field decode, branch/jump target shaping and load-use hazard detection.
// Optional performance counters are built only when IF_ID_PERF_COUNTERS_EN is defined.
module if_id_stage #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic [31:0]      PC,
    input  logic             flush,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    output logic [31:0]      if_id_instruction,
    output logic [31:0]      if_id_pc_plus4,
    output logic             if_id_valid,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [31:0]      imm_sext,
    output logic [31:0]      shifted,
    output logic [27:0]      Jump_address,
    output logic             stall,
    output logic             id_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [31:0] pc_plus4;
    logic        rt_used;

    assign pc_plus4 = PC + 32'd4;

    // Falling-edge capture keeps this register in step with the PC register in instruction_fetch.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            if_id_instruction <= NOP_WORD;
            if_id_pc_plus4    <= 32'd0;
            if_id_valid       <= 1'b0;
        end else if (flush) begin
            if_id_instruction <= NOP_WORD;
            if_id_pc_plus4    <= pc_plus4;
            if_id_valid       <= 1'b0;
        end else if (!stall) begin
            if_id_instruction <= instruction;
            if_id_pc_plus4    <= pc_plus4;
            if_id_valid       <= 1'b1;
        end
    end

    assign opcode       = if_id_instruction[31:26];
    assign rs           = if_id_instruction[25:21];
    assign rt           = if_id_instruction[20:16];
    assign rd           = if_id_instruction[15:11];
    assign shamt        = if_id_instruction[10:6];
    assign funct        = if_id_instruction[5:0];
    assign imm_sext     = {{16{if_id_instruction[15]}}, if_id_instruction[15:0]};
    assign shifted      = imm_sext << 2;
    assign Jump_address = {if_id_instruction[25:0], 2'b00};

    // Only these formats read rt as a source; loads, immediates and jumps write or ignore it.
    assign rt_used = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE)   || (opcode == OP_SW);

    assign stall = if_id_valid && id_ex_mem_read && (id_ex_rt != 5'd0) &&
                   ((id_ex_rt == rs) || (rt_used && (id_ex_rt == rt)));

    assign id_bubble = stall || !if_id_valid;

`ifdef IF_ID_PERF_COUNTERS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Both counters saturate rather than wrap so a long run never reports a small value.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && !flush && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage; inputs change and outputs are sampled
// between falling edges, away from the active edge.
module tb_if_id_stage;

    localparam int CNT_W = 32;

`ifdef IF_ID_PERF_COUNTERS_EN
    localparam logic [CNT_W-1:0] EXP_FLUSH_ONE   = 1;
    localparam logic [CNT_W-1:0] EXP_STALL_THREE = 3;
`else
    localparam logic [CNT_W-1:0] EXP_FLUSH_ONE   = 0;
    localparam logic [CNT_W-1:0] EXP_STALL_THREE = 0;
`endif

    logic             clk = 1'b1;
    logic             reset;
    logic [31:0]      instruction;
    logic [31:0]      PC;
    logic             flush;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rt;
    logic [31:0]      if_id_instruction;
    logic [31:0]      if_id_pc_plus4;
    logic             if_id_valid;
    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [5:0]       funct;
    logic [31:0]      imm_sext;
    logic [31:0]      shifted;
    logic [27:0]      Jump_address;
    logic             stall;
    logic             id_bubble;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int passed = 0;
    int total  = 0;

    if_id_stage #(.NOP_WORD(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .instruction       (instruction),
        .PC                (PC),
        .flush             (flush),
        .id_ex_mem_read    (id_ex_mem_read),
        .id_ex_rt          (id_ex_rt),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .opcode            (opcode),
        .rs                (rs),
        .rt                (rt),
        .rd                (rd),
        .shamt             (shamt),
        .funct             (funct),
        .imm_sext          (imm_sext),
        .shifted           (shifted),
        .Jump_address      (Jump_address),
        .stall             (stall),
        .id_bubble         (id_bubble),
        .stall_count       (stall_count),
        .flush_count       (flush_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        instruction    = 32'h8C08_0004;
        PC             = 32'h0000_0100;
        flush          = 1'b0;
        id_ex_mem_read = 1'b0;
        id_ex_rt       = 5'd0;
        repeat (2) tick();
        total++; if (if_id_instruction !== 32'h0) $display("FAIL reset_instr got %h exp %h", if_id_instruction, 32'h0); else passed++;
        total++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", if_id_valid); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else passed++;
        total++; if (Jump_address !== 28'h0) $display("FAIL reset_jump got %h exp 0", Jump_address); else passed++;
        total++; if (if_id_pc_plus4 !== 32'h0) $display("FAIL reset_pc4 got %h exp 0", if_id_pc_plus4); else passed++;
        total++; if (stall_count !== '0 || flush_count !== '0) $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_count, flush_count); else passed++;
        reset = 1'b1;
        tick();
        total++; if (if_id_instruction !== 32'h8C08_0004) $display("FAIL release_instr got %h exp %h", if_id_instruction, 32'h8C08_0004); else passed++;
        total++; if (if_id_pc_plus4 !== 32'h0000_0104) $display("FAIL release_pc4 got %h exp %h", if_id_pc_plus4, 32'h104); else passed++;
        total++; if (if_id_valid !== 1'b1) $display("FAIL release_valid got %b exp 1", if_id_valid); else passed++;
    endtask

    task automatic test_decode();
        instruction = 32'h1109_FFFE;
        PC          = 32'h0000_0040;
        tick();
        total++; if (opcode !== 6'h04) $display("FAIL dec_opcode got %h exp 04", opcode); else passed++;
        total++; if (rs !== 5'd8) $display("FAIL dec_rs got %0d exp 8", rs); else passed++;
        total++; if (rt !== 5'd9) $display("FAIL dec_rt got %0d exp 9", rt); else passed++;
        total++; if (imm_sext !== 32'hFFFF_FFFE) $display("FAIL dec_imm got %h exp FFFFFFFE", imm_sext); else passed++;
        total++; if (shifted !== 32'hFFFF_FFF8) $display("FAIL dec_shifted got %h exp FFFFFFF8", shifted); else passed++;
        total++; if (if_id_pc_plus4 !== 32'h0000_0044) $display("FAIL dec_pc4 got %h exp 44", if_id_pc_plus4); else passed++;
        total++; if (Jump_address !== 28'h427_FFF8) $display("FAIL dec_jump got %h exp 427FFF8", Jump_address); else passed++;
        total++; if (id_bubble !== 1'b0) $display("FAIL dec_bubble got %b exp 0", id_bubble); else passed++;
    endtask

    task automatic test_load_use();
        instruction = 32'h0109_5020;
        PC          = 32'h0000_0080;
        tick();
        instruction    = 32'hDEAD_BEEF;
        PC             = 32'h0000_0084;
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd8;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL lu_rs_stall got %b exp 1", stall); else passed++;
        id_ex_rt = 5'd9;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL lu_rt_stall got %b exp 1", stall); else passed++;
        total++; if (id_bubble !== 1'b1) $display("FAIL lu_bubble got %b exp 1", id_bubble); else passed++;
        tick();
        total++; if (if_id_instruction !== 32'h0109_5020) $display("FAIL lu_hold_instr got %h exp 01095020", if_id_instruction); else passed++;
        total++; if (if_id_pc_plus4 !== 32'h0000_0084) $display("FAIL lu_hold_pc4 got %h exp 84", if_id_pc_plus4); else passed++;
        total++; if (rd !== 5'd10 || funct !== 6'h20 || shamt !== 5'd0) $display("FAIL lu_rtype_fields got rd=%0d funct=%h shamt=%0d exp 10/20/0", rd, funct, shamt); else passed++;
        id_ex_mem_read = 1'b0;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL lu_release_stall got %b exp 0", stall); else passed++;
        tick();
        total++; if (if_id_instruction !== 32'hDEAD_BEEF) $display("FAIL lu_resume_instr got %h exp DEADBEEF", if_id_instruction); else passed++;
        total++; if (if_id_pc_plus4 !== 32'h0000_0088) $display("FAIL lu_resume_pc4 got %h exp 88", if_id_pc_plus4); else passed++;
    endtask

    task automatic test_no_false_stall();
        id_ex_mem_read = 1'b0;
        instruction    = 32'h0009_5020;
        PC             = 32'h0000_0090;
        tick();
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd0;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL nfs_zero_reg got %b exp 0", stall); else passed++;
        id_ex_mem_read = 1'b0;
        instruction    = 32'h8C09_0004;
        tick();
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd9;
        #1;
        total++; if (stall !== 1'b0 || id_bubble !== 1'b0) $display("FAIL nfs_lw_rt got stall=%b bubble=%b exp 0/0", stall, id_bubble); else passed++;
        id_ex_mem_read = 1'b0;
        instruction    = 32'hAD09_0000;
        tick();
        id_ex_mem_read = 1'b1;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL nfs_sw_rt got %b exp 1", stall); else passed++;
        id_ex_mem_read = 1'b0;
    endtask

    task automatic test_flush_during_stall();
        reset_pulse();
        instruction = 32'h0109_5020;
        PC          = 32'h0000_00A0;
        tick();
        instruction    = 32'h1234_5678;
        PC             = 32'h0000_00A4;
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd9;
        flush          = 1'b1;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL fl_pre_stall got %b exp 1", stall); else passed++;
        tick();
        flush = 1'b0;
        #1;
        total++; if (if_id_instruction !== 32'h0) $display("FAIL fl_instr got %h exp 0", if_id_instruction); else passed++;
        total++; if (if_id_valid !== 1'b0) $display("FAIL fl_valid got %b exp 0", if_id_valid); else passed++;
        total++; if (if_id_pc_plus4 !== 32'h0000_00A8) $display("FAIL fl_pc4 got %h exp A8", if_id_pc_plus4); else passed++;
        total++; if (stall !== 1'b0 || id_bubble !== 1'b1) $display("FAIL fl_post got stall=%b bubble=%b exp 0/1", stall, id_bubble); else passed++;
        total++; if (flush_count !== EXP_FLUSH_ONE) $display("FAIL fl_flush_count got %0d exp %0d", flush_count, EXP_FLUSH_ONE); else passed++;
        total++; if (stall_count !== '0) $display("FAIL fl_stall_count got %0d exp 0", stall_count); else passed++;
        id_ex_mem_read = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        instruction = 32'h0109_5020;
        PC          = 32'h0000_00C0;
        tick();
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd9;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL rms_pre_stall got %b exp 1", stall); else passed++;
        reset = 1'b0;
        #1;
        total++; if (if_id_instruction !== 32'h0 || if_id_valid !== 1'b0 || stall !== 1'b0) $display("FAIL rms_async got instr=%h valid=%b stall=%b exp 0/0/0", if_id_instruction, if_id_valid, stall); else passed++;
        reset          = 1'b1;
        id_ex_mem_read = 1'b0;
        #1;
    endtask

    task automatic test_wrap();
        reset_pulse();
        instruction = 32'h0109_5020;
        PC          = 32'hFFFF_FFFC;
        tick();
        total++; if (if_id_pc_plus4 !== 32'h0) $display("FAIL wrap_pc4 got %h exp 0", if_id_pc_plus4); else passed++;
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd9;
        PC             = 32'h0000_0000;
        repeat (3) tick();
        total++; if (stall_count !== EXP_STALL_THREE) $display("FAIL wrap_stall_count got %0d exp %0d", stall_count, EXP_STALL_THREE); else passed++;
        total++; if (if_id_instruction !== 32'h0109_5020 || if_id_pc_plus4 !== 32'h0) $display("FAIL wrap_hold got %h/%h exp 01095020/0", if_id_instruction, if_id_pc_plus4); else passed++;
        id_ex_mem_read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_load_use();
        test_no_false_stall();
        test_flush_during_stall();
        test_reset_mid_stall();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
